freq_meter: RTL and testbench

Gated-window frequency counter that measures a slow asynchronous clock-like signal, such as a low-frequency oscillator output or an encoder/step line, against the system clock.
- Counts rising edges of the synchronized input over a fixed window of GATE_CYCLES system clocks, then reports the count.
- Sits beside the oscillator block as its consumer/checker: power-on self-test of LF/HF oscillator outputs and "clock stuck" detection.
- Valid only for sig_in frequencies below clk/4; faster inputs alias and are out of scope.

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/freq_meter.sv | 133 +++++++++++++
 tb/tb_freq_meter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated-window frequency meter.
//   fm_state_e     : measurement FSM states
//   gate_cnt_width : width of the window (gate) counter for a given window length
package freq_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGate,
    StDone
  } fm_state_e;

  // Enough bits to hold 0 .. gate_cycles-1; never narrower than one bit.
  function automatic int unsigned gate_cnt_width(input int unsigned gate_cycles);
    int unsigned w;
    w = 32'($clog2(gate_cycles));
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a history flop producing a one-cycle rising-edge strobe.
// Usable for any slow asynchronous input (oscillator taps, step/dir lines, ...).
//   clk      : sampling clock
//   resetn   : asynchronous active-low reset, clears all three flops
//   async_in : asynchronous input
//   rise     : high for one clk cycle after each synchronized 0->1 transition
module sync_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rise = sync_q & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency counter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clk cycles and reports the count, a saturation flag and a zero-edge flag.
//   clk, resetn : system clock, asynchronous active-low reset
//   sig_in      : asynchronous signal under measurement (must be below clk/4)
//   enable      : block enable; low aborts any open window without a result
//   start       : one-cycle window request (ignored when CONTINUOUS=1)
//   busy        : high while a window is open
//   freq_count  : edge count of the last completed window
//   valid       : one-cycle pulse when freq_count/overflow/stuck update
//   overflow    : last window saturated the edge counter
//   stuck       : last window saw zero edges
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 48000,
  parameter int unsigned CNT_W       = 16,
  parameter bit          CONTINUOUS  = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             overflow,
  output logic             stuck
);

  localparam int unsigned      GateW  = gate_cnt_width(GATE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  fm_state_e        state_q;
  logic [GateW-1:0] gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             ovf_q;

  logic             rise;
  logic             go;
  logic             window_last;
  logic [CNT_W-1:0] edge_cnt_inc;
  logic             ovf_inc;

  sync_edge_detect u_sync_edge_detect (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (sig_in),
    .rise     (rise)
  );

  assign go = CONTINUOUS ? enable : (enable & start);

  // Zero-extend the counter rather than truncate the constant.
  assign window_last = (32'(gate_cnt_q) == (GATE_CYCLES - 32'd1));

  // Edge count including this cycle's edge; used both for the running count and
  // for the result latched on the last gate cycle, so that edge is not lost.
  always_comb begin
    edge_cnt_inc = edge_cnt_q;
    ovf_inc      = ovf_q;
    if (rise) begin
      if (edge_cnt_q == CntMax) begin
        ovf_inc = 1'b1;
      end else begin
        edge_cnt_inc = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      freq_count <= '0;
      overflow   <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q    <= StGate;
            busy       <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end
        end
        StGate: begin
          if (!enable) begin
            // Abort wins over a same-cycle window end; results are left untouched.
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            gate_cnt_q <= gate_cnt_q + GateW'(1);
            edge_cnt_q <= edge_cnt_inc;
            ovf_q      <= ovf_inc;
            if (window_last) begin
              // Result registers and valid become visible together in the DONE cycle.
              state_q    <= StDone;
              busy       <= 1'b0;
              valid      <= 1'b1;
              freq_count <= edge_cnt_inc;
              overflow   <= ovf_inc;
              stuck      <= (edge_cnt_inc == '0);
            end
          end
        end
        StDone: begin
          if (CONTINUOUS && enable) begin
            state_q    <= StGate;
            busy       <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: three instances share clk/resetn.
//   u_a : GATE_CYCLES=100, CNT_W=8, single-shot
//   u_b : GATE_CYCLES=100, CNT_W=4, single-shot (saturation)
//   u_c : GATE_CYCLES=100, CNT_W=8, continuous
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic       sig_a, en_a, start_a, busy_a, valid_a, ovf_a, stuck_a;
  logic [7:0] fc_a;
  logic       sig_b, en_b, start_b, busy_b, valid_b, ovf_b, stuck_b;
  logic [3:0] fc_b;
  logic       sig_c, en_c, start_c, busy_c, valid_c, ovf_c, stuck_c;
  logic [7:0] fc_c;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .CONTINUOUS(1'b0)) u_a (
    .clk(clk), .resetn(resetn), .sig_in(sig_a), .enable(en_a), .start(start_a),
    .busy(busy_a), .freq_count(fc_a), .valid(valid_a), .overflow(ovf_a), .stuck(stuck_a)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .CONTINUOUS(1'b0)) u_b (
    .clk(clk), .resetn(resetn), .sig_in(sig_b), .enable(en_b), .start(start_b),
    .busy(busy_b), .freq_count(fc_b), .valid(valid_b), .overflow(ovf_b), .stuck(stuck_b)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .CONTINUOUS(1'b1)) u_c (
    .clk(clk), .resetn(resetn), .sig_in(sig_c), .enable(en_c), .start(start_c),
    .busy(busy_c), .freq_count(fc_c), .valid(valid_c), .overflow(ovf_c), .stuck(stuck_c)
  );

  // Square-wave generators; period 0 holds the line low.
  int per_a = 10, per_b = 4, per_c = 20;
  int ph_a = 0, ph_b = 0, ph_c = 0;

  always @(negedge clk) begin
    ph_a  = (per_a == 0) ? 0 : (ph_a + 1) % per_a;
    sig_a = (per_a != 0) && (ph_a < per_a / 2);
    ph_b  = (per_b == 0) ? 0 : (ph_b + 1) % per_b;
    sig_b = (per_b != 0) && (ph_b < per_b / 2);
    ph_c  = (per_c == 0) ? 0 : (ph_c + 1) % per_c;
    sig_c = (per_c != 0) && (ph_c < per_c / 2);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Samples u_a at each negedge for n cycles.
  task automatic watch_a(input int n, output int busy_n, output int valid_n,
                         output int fc_seen);
    busy_n  = 0;
    valid_n = 0;
    fc_seen = -1;
    for (int i = 0; i < n; i++) begin
      if (busy_a) busy_n++;
      if (valid_a) begin
        valid_n++;
        fc_seen = int'(fc_a);
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start_a();
    en_a    = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  int bn, vn, fs, bn2, vn2, fs2;
  int tv[3];
  int fcv[3];
  int nv, t;

  initial begin
    resetn  = 1'b0;
    en_a = 1'b0; start_a = 1'b0;
    en_b = 1'b0; start_b = 1'b0;
    en_c = 1'b0; start_c = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_fc_a", 32'(fc_a), 0);
    check("rst_ovf_a", 32'(ovf_a), 0);
    check("rst_stuck_a", 32'(stuck_a), 0);
    check("rst_busy_c", 32'(busy_c), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: period 10 over 100 cycles, with an extra start inside the window
    pulse_start_a();
    watch_a(40, bn, vn, fs);
    if (busy_a) bn++;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    watch_a(109, bn2, vn2, fs2);
    check("t1_busy_cycles", 32'(bn + bn2), 100);
    check("t1_valid_pulses", 32'(vn + vn2), 1);
    check("t1_fc_at_valid", 32'(fs2), 10);
    check("t1_fc", 32'(fc_a), 10);
    check("t1_ovf", 32'(ovf_a), 0);
    check("t1_stuck", 32'(stuck_a), 0);

    // 5: abort at gate cycle 50, results hold
    pulse_start_a();
    repeat (49) @(negedge clk);
    check("t5_busy_before", 32'(busy_a), 1);
    en_a = 1'b0;
    @(negedge clk);
    check("t5_busy_after", 32'(busy_a), 0);
    watch_a(120, bn, vn, fs);
    check("t5_no_valid", 32'(vn), 0);
    check("t5_fc_hold", 32'(fc_a), 10);
    check("t5_stuck_hold", 32'(stuck_a), 0);
    check("t5_ovf_hold", 32'(ovf_a), 0);

    // 2: input held low for the whole window
    per_a = 0;
    repeat (6) @(negedge clk);
    pulse_start_a();
    watch_a(150, bn, vn, fs);
    check("t2_valid_pulses", 32'(vn), 1);
    check("t2_fc", 32'(fc_a), 0);
    check("t2_stuck", 32'(stuck_a), 1);
    check("t2_ovf", 32'(ovf_a), 0);

    // 3: 25 edges into a 4-bit counter saturates at 15
    en_b    = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    vn = 0;
    for (int i = 0; i < 150; i++) begin
      if (valid_b) vn++;
      @(negedge clk);
    end
    check("t3_valid_pulses", 32'(vn), 1);
    check("t3_fc", 32'(fc_b), 15);
    check("t3_ovf", 32'(ovf_b), 1);
    check("t3_stuck", 32'(stuck_b), 0);

    // Abort on u_b: overflow and count must hold
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (20) @(negedge clk);
    en_b = 1'b0;
    vn = 0;
    for (int i = 0; i < 120; i++) begin
      if (valid_b) vn++;
      @(negedge clk);
    end
    check("t3b_no_valid", 32'(vn), 0);
    check("t3b_fc_hold", 32'(fc_b), 15);
    check("t3b_ovf_hold", 32'(ovf_b), 1);

    // 4: continuous mode, three windows of period-20 input
    tv  = '{0, 0, 0};
    fcv = '{0, 0, 0};
    nv  = 0;
    t   = 0;
    en_c = 1'b1;
    for (int i = 0; i < 400 && nv < 3; i++) begin
      @(negedge clk);
      t++;
      if (valid_c) begin
        tv[nv]  = t;
        fcv[nv] = int'(fc_c);
        nv++;
      end
    end
    en_c = 1'b0;
    check("t4_windows", 32'(nv), 3);
    check("t4_fc0", 32'(fcv[0]), 5);
    check("t4_fc1", 32'(fcv[1]), 5);
    check("t4_fc2", 32'(fcv[2]), 5);
    check("t4_spacing01", 32'(tv[1] - tv[0]), 101);
    check("t4_spacing12", 32'(tv[2] - tv[1]), 101);
    repeat (3) @(negedge clk);
    check("t4_idle_busy", 32'(busy_c), 0);

    // 6: reset mid-window, then a fresh full window
    per_a = 10;
    repeat (5) @(negedge clk);
    pulse_start_a();
    repeat (29) @(negedge clk);
    check("t6_busy_mid", 32'(busy_a), 1);
    resetn = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy_a), 0);
    check("t6_rst_valid", 32'(valid_a), 0);
    check("t6_rst_fc", 32'(fc_a), 0);
    check("t6_rst_stuck", 32'(stuck_a), 0);
    check("t6_rst_ovf", 32'(ovf_a), 0);
    check("t6_rst_fc_b", 32'(fc_b), 0);
    check("t6_rst_ovf_b", 32'(ovf_b), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start_a();
    watch_a(150, bn, vn, fs);
    check("t6_busy_cycles", 32'(bn), 100);
    check("t6_valid_pulses", 32'(vn), 1);
    check("t6_fc", 32'(fc_a), 10);
    check("t6_stuck", 32'(stuck_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
